// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score accumulator.
package score_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ADD  = 1'b1
  } state_e;

  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [4:0] BCD_BASE = 5'd10;

  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with carry; purely combinational.
module bcd_digit_add
  import score_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout
);

  logic [DIGIT_W:0] s;

  // s <= 19, so subtracting 10 modulo 16 on the low nibble gives the exact digit.
  always_comb begin
    s    = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    cout = (s >= BCD_BASE);
    sum  = cout ? (s[DIGIT_W-1:0] - BCD_BASE[DIGIT_W-1:0]) : s[DIGIT_W-1:0];
  end

endmodule

// File: rtl/score_bcd_counter.sv
// Multi-digit BCD score accumulator: ripples one digit per clock and exposes
// a copy of the score that only updates at frame boundaries.
module score_bcd_counter
  import score_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       add_valid,
  output logic                       add_ready,
  input  logic [7:0]                 add_amount,
  input  logic                       frame_tick,
  output logic [DIGIT_W*NDIGITS-1:0] disp_digits,
  output logic                       overflow,
  output logic                       busy
);

  localparam int               IDX_W = $clog2(NDIGITS);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NDIGITS - 1);

  state_e                                state_q, state_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic                                  carry_q, carry_d;
  logic [7:0]                            amt_q, amt_d;
  logic [NDIGITS-1:0][DIGIT_W-1:0]       work_q, work_d;
  logic [NDIGITS-1:0][DIGIT_W-1:0]       disp_q, disp_d;
  logic                                  ovf_q, ovf_d;
  logic                                  pend_q, pend_d;

  logic [DIGIT_W-1:0] dig_a, dig_b, dig_sum;
  logic               dig_cout;

  // Single shared digit adder, steered by idx.
  always_comb begin
    dig_a = work_q[idx_q];
    if (idx_q == '0)             dig_b = amt_q[3:0];
    else if (idx_q == IDX_W'(1)) dig_b = amt_q[7:4];
    else                         dig_b = '0;
  end

  bcd_digit_add u_dig (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  assign add_ready   = (state_q == ST_IDLE) && !clear;
  assign busy        = (state_q == ST_ADD);
  assign overflow    = ovf_q;
  assign disp_digits = disp_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    amt_d   = amt_q;
    work_d  = work_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    pend_d  = pend_q;

    // Display latch is independent of clear: it sees the pre-clear value.
    if (state_q == ST_IDLE && (frame_tick || pend_q)) begin
      disp_d = work_q;
      pend_d = 1'b0;
    end else if (state_q == ST_ADD && frame_tick) begin
      pend_d = 1'b1;
    end

    if (clear) begin
      work_d  = '0;
      ovf_d   = 1'b0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (add_valid) begin
            amt_d   = {bcd_clamp(add_amount[7:4]), bcd_clamp(add_amount[3:0])};
            idx_d   = '0;
            carry_d = 1'b0;
            state_d = ST_ADD;
          end
        end
        ST_ADD: begin
          work_d[idx_q] = dig_sum;
          carry_d       = dig_cout;
          idx_d         = idx_q + IDX_W'(1);
          if (idx_q == LAST) begin
            state_d = ST_IDLE;
            if (dig_cout) begin
              ovf_d = 1'b1;
              if (SATURATE) begin
                for (int i = 0; i < NDIGITS; i++) work_d[i] = BCD_MAX;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      amt_q   <= '0;
      work_q  <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      amt_q   <= amt_d;
      work_q  <= work_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
Multi-digit BCD score accumulator that feeds the digit-bitmap ROM stage of the scoreboard display. Game logic posts BCD add requests over a valid/ready handshake. The block ripples the addition one digit per clock. It exposes a frame-stable copy of the score, updated only at frame boundaries, so the renderer never shows a half-updated value mid-frame.

Parameters:
NDIGITS, 4, number of BCD digits held (legal range 2..8)
SATURATE, 1, 1 = on overflow clamp to all-9s; 0 = wrap modulo 10^NDIGITS

Ports:
clk  input  1  system clock (pixel clock domain)
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous score clear request
add_valid  input  1  add request valid
add_ready  output  1  block can accept an add this cycle
add_amount  input  8  two-digit BCD operand; [3:0] ones, [7:4] tens
frame_tick  input  1  one-cycle pulse at start of vertical blank
disp_digits  output  4*NDIGITS  frame-stable score; digit i at [4i+3:4i], digit 0 = ones
overflow  output  1  sticky; set when an add carries out of the top digit
busy  output  1  high while an addition is in progress

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. All state changes on the rising edge.
- Reset values:
  - working score = 0, disp_digits = 0
  - overflow = 0, busy = 0, add_ready = 1
  - state = IDLE, latch_pending = 0
- States:
  - IDLE: waiting for a request.
  - ADD: processing digit index idx, from 0 to NDIGITS-1.
- add_ready = (state==IDLE) && !clear. busy = (state==ADD).
- Acceptance:
  - A request is accepted at an edge where add_valid && add_ready are both high.
  - On acceptance, capture add_amount with each nibble >9 clamped to 9, set idx=0 and carry=0, and go to ADD.
- ADD step, one digit per edge:
  - operand digit = amount[3:0] when idx=0, amount[7:4] when idx=1, otherwise 0.
  - s = work[idx] + operand + carry, computed at 5-bit width.
  - If s>9: work[idx]=s-10 and carry=1. Otherwise work[idx]=s and carry=0.
  - idx increments each step.
- Final digit (idx=NDIGITS-1):
  - Return to IDLE.
  - If the final carry is 1: set overflow=1. If SATURATE=1, write all working digits to 9 instead of the computed value. If SATURATE=0, keep the wrapped value.
- Latency: the working score reflects the add NDIGITS edges after the acceptance edge. add_ready is high again in the cycle after that edge. Throughput is one add per NDIGITS+1 cycles.
- clear:
  - Has priority over add_valid and over an in-progress ADD.
  - At an edge with clear=1: working score=0, overflow=0, state=IDLE. An aborted add is discarded entirely.
  - Does not touch disp_digits or latch_pending.
- Display latch:
  - At an edge with state==IDLE and (frame_tick || latch_pending): disp_digits <= working score and latch_pending <= 0.
  - frame_tick while state==ADD sets latch_pending=1. The latch happens at the first edge the FSM is in IDLE, so disp_digits never shows a partially rippled sum.
  - frame_tick on the same edge as an acceptance latches the pre-add value.
  - frame_tick on the same edge as clear latches the pre-clear value; the cleared value appears on the next frame.
- Reset mid-operation: reset overrides everything and returns all state to the reset values above.
- Widths: work and disp_digits are 4*NDIGITS bits. The digit adder is 5 bits internally. No output ever holds a nibble >9.

Decomposition:
- Shared package score_pkg:
  - state encoding: ST_IDLE, ST_ADD
  - BCD_MAX = 4'd9, BCD_BASE = 5'd10
  - digit width constant DIGIT_W = 4
  - a BCD clamp helper for nibbles >9
- One sub-module: bcd_digit_add. Purely combinational; inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout. The top instantiates one copy, shared across idx through a mux.

Test Plan:
- Reset, then a frame_tick pulse → disp_digits=0x0000, overflow=0, add_ready=1.
- Add 8'h07 to score 0005 → add_ready low for 4 cycles; next frame_tick gives disp 0x0012.
- Score 9990, add 8'h15, SATURATE=1 → disp 0x9999 and overflow=1. Same with SATURATE=0 → disp 0x0005 and overflow=1.
- frame_tick asserted 2 cycles after acceptance (score 0099 + 8'h01) → disp holds 0x0099 until the ADD completes, then latches 0x0100 on the first IDLE edge without another tick.
- clear asserted at idx=2 of an add of 8'h50 to 1234 → working=0 and overflow=0. The next frame_tick gives disp 0x0000; add_ready is low during clear.
- add_amount=8'hFA (illegal nibbles) added to 0000 → treated as 0x99, so disp 0x0099.
